// File: rtl/led_frame_scheduler.sv
// LED frame scheduler: turns framerate edges into buffer swaps, paces the
// encoder through NUM_LEDS x BITS_PER_LED bit periods, then a latch gap.
module led_frame_scheduler #(
  parameter int NUM_LEDS     = 60,
  parameter int BITS_PER_LED = 24,
  parameter int RESET_TICKS  = 40
) (
  input  logic       clock_12mhz,
  input  logic       reset_n,
  input  logic       framerate,
  input  logic       bit_tick,
  input  logic       buffer_valid,
  output logic       buffer_swap,
  output logic       encoder_enable,
  output logic       encoder_reset,
  output logic [7:0] led_index,
  output logic [4:0] bit_index,
  output logic       frame_done,
  output logic       busy,
  output logic [7:0] dropped_frames
);

  localparam logic [7:0]  LED_LAST = 8'(NUM_LEDS - 1);
  localparam logic [4:0]  BIT_LAST = 5'(BITS_PER_LED - 1);
  localparam logic [15:0] LAT_LAST = 16'(RESET_TICKS - 1);

  typedef enum logic [1:0] {S_IDLE, S_SHIFT, S_LATCH} state_t;

  state_t      r_state, w_state_nxt;
  logic        r_fr_prev, r_armed, r_pending, w_pending_nxt;
  logic [15:0] r_lcnt, w_lcnt_nxt;
  logic        r_swap, w_swap_nxt, r_done, w_done_nxt;
  logic        r_en, w_en_nxt, r_rst, w_rst_nxt, r_busy;
  logic [7:0]  r_led, w_led_nxt, r_drop, w_drop_nxt;
  logic [4:0]  r_bit, w_bit_nxt;
  logic        w_req, w_drop_inc;

  // The first cycle after reset only captures framerate, so a level already
  // high at release is never mistaken for an edge.
  assign w_req = r_armed && (framerate != r_fr_prev);

  always_comb begin
    w_state_nxt   = r_state;
    w_pending_nxt = r_pending;
    w_lcnt_nxt    = r_lcnt;
    w_swap_nxt    = 1'b0;
    w_done_nxt    = 1'b0;
    w_en_nxt      = r_en;
    w_rst_nxt     = r_rst;
    w_led_nxt     = r_led;
    w_bit_nxt     = r_bit;
    w_drop_inc    = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (w_req || r_pending) begin
          w_pending_nxt = 1'b0;
          if (buffer_valid) begin
            w_state_nxt = S_SHIFT;
            w_swap_nxt  = 1'b1;
            w_en_nxt    = 1'b1;
            w_led_nxt   = '0;
            w_bit_nxt   = '0;
          end else begin
            w_drop_inc = 1'b1;
          end
        end
      end
      S_SHIFT: begin
        if (bit_tick) begin
          if (r_bit == BIT_LAST) begin
            w_bit_nxt = '0;
            if (r_led == LED_LAST) begin
              w_state_nxt = S_LATCH;
              w_en_nxt    = 1'b0;
              w_rst_nxt   = 1'b1;
              w_led_nxt   = '0;
              w_lcnt_nxt  = '0;
            end else begin
              w_led_nxt = r_led + 8'd1;
            end
          end else begin
            w_bit_nxt = r_bit + 5'd1;
          end
        end
      end
      S_LATCH: begin
        if (bit_tick) begin
          w_lcnt_nxt = r_lcnt + 16'd1;
          if (r_lcnt == LAT_LAST) begin
            w_state_nxt = S_IDLE;
            w_rst_nxt   = 1'b0;
            w_done_nxt  = 1'b1;
          end
        end
      end
      default: w_state_nxt = S_IDLE;
    endcase
    // A request while busy (including on a transition edge) queues one deep.
    if (r_state != S_IDLE && w_req) begin
      if (!r_pending) w_pending_nxt = 1'b1;
      else            w_drop_inc    = 1'b1;
    end
  end

  assign w_drop_nxt = (w_drop_inc && r_drop != 8'hFF) ? r_drop + 8'd1 : r_drop;

  always_ff @(posedge clock_12mhz or negedge reset_n) begin
    if (!reset_n) begin
      r_state   <= S_IDLE;
      r_fr_prev <= 1'b0;
      r_armed   <= 1'b0;
      r_pending <= 1'b0;
      r_lcnt    <= '0;
      r_swap    <= 1'b0;
      r_done    <= 1'b0;
      r_en      <= 1'b0;
      r_rst     <= 1'b0;
      r_busy    <= 1'b0;
      r_led     <= '0;
      r_bit     <= '0;
      r_drop    <= '0;
    end else begin
      r_state   <= w_state_nxt;
      r_fr_prev <= framerate;
      r_armed   <= 1'b1;
      r_pending <= w_pending_nxt;
      r_lcnt    <= w_lcnt_nxt;
      r_swap    <= w_swap_nxt;
      r_done    <= w_done_nxt;
      r_en      <= w_en_nxt;
      r_rst     <= w_rst_nxt;
      r_busy    <= (w_state_nxt != S_IDLE);
      r_led     <= w_led_nxt;
      r_bit     <= w_bit_nxt;
      r_drop    <= w_drop_nxt;
    end
  end

  assign buffer_swap    = r_swap;
  assign encoder_enable = r_en;
  assign encoder_reset  = r_rst;
  assign led_index      = r_led;
  assign bit_index      = r_bit;
  assign frame_done     = r_done;
  assign busy           = r_busy;
  assign dropped_frames = r_drop;

endmodule

// File: tb/tb_led_frame_scheduler.sv
// Scoreboard bench for led_frame_scheduler: stimulus pushes expected swap/done
// events with their cycle numbers, a monitor pops them as the DUT pulses.
module tb_led_frame_scheduler;
  localparam int NL  = 2;
  localparam int BPL = 24;
  localparam int RT  = 3;

  typedef struct { logic done; int cyc; } exp_t;

  logic       clk = 1'b0, rst_n = 1'b0, framerate = 1'b0, buffer_valid = 1'b1;
  logic       bit_tick;
  logic       buffer_swap, encoder_enable, encoder_reset, frame_done, busy;
  logic [7:0] led_index, dropped_frames;
  logic [4:0] bit_index;

  int   cyc = 0, checks = 0, errors = 0;
  int   en_cnt = 0, rst_cnt = 0;
  bit   stim_done = 1'b0;
  exp_t sb[$];
  exp_t e;

  led_frame_scheduler #(.NUM_LEDS(NL), .BITS_PER_LED(BPL), .RESET_TICKS(RT)) dut (
    .clock_12mhz(clk), .reset_n(rst_n), .framerate(framerate), .bit_tick(bit_tick),
    .buffer_valid(buffer_valid), .buffer_swap(buffer_swap), .encoder_enable(encoder_enable),
    .encoder_reset(encoder_reset), .led_index(led_index), .bit_index(bit_index),
    .frame_done(frame_done), .busy(busy), .dropped_frames(dropped_frames));

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;
  assign bit_tick = (cyc % 16 == 15);

  task automatic check(input string nm, input int got, input int want);
    checks++;
    if (got != want) begin
      errors++;
      $display("FAIL %s: got %0d, expected %0d (cycle %0d)", nm, got, want, cyc);
    end
  endtask

  // Cycle of the n-th bit_tick at or after cycle 'from'.
  function automatic int tick_at(input int from, input int n);
    return from + (15 - from % 16) + 16 * (n - 1);
  endfunction

  task automatic push_frame(input int t, output int d);
    int t48;
    sb.push_back('{1'b0, t + 1});
    t48 = tick_at(t + 1, NL * BPL);
    d   = tick_at(t48 + 1, RT) + 1;
    sb.push_back('{1'b1, d});
  endtask

  task automatic toggle(output int t);
    @(negedge clk);
    framerate = ~framerate;
    t = cyc;
  endtask

  task automatic wait_until(input int c);
    while (cyc < c) @(negedge clk);
  endtask

  initial begin
    fork
      begin : stim
        int t, d, d2, n;
        repeat (3) @(negedge clk);
        check("reset_outputs", int'({buffer_swap, encoder_enable, encoder_reset, led_index,
              bit_index, frame_done, busy, dropped_frames}), 0);
        rst_n = 1'b1;
        repeat (3) @(negedge clk);

        toggle(t); push_frame(t, d); wait_until(d + 4);

        buffer_valid = 1'b0;
        toggle(t);
        repeat (5) @(negedge clk);
        check("starved_dropped", dropped_frames, 1);
        check("starved_idle", busy, 0);
        buffer_valid = 1'b1;

        toggle(t); push_frame(t, d);
        repeat (100) @(negedge clk);
        toggle(t);
        repeat (100) @(negedge clk);
        toggle(t);
        push_frame(d, d2);
        wait_until(d2 + 4);
        check("overlap_dropped", dropped_frames, 2);

        toggle(t);
        sb.push_back('{1'b0, t + 1});
        n = 0;
        while (!(led_index == 8'd1 && bit_index == 5'd10) && n < 2000) begin
          @(negedge clk);
          n++;
        end
        check("reach_led1_bit10", int'(n < 2000), 1);
        rst_n = 1'b0;
        #1;
        check("midframe_reset_outputs", int'({buffer_swap, encoder_enable, encoder_reset,
              led_index, bit_index, frame_done, busy, dropped_frames}), 0);
        repeat (20) @(negedge clk);
        rst_n = 1'b1;
        repeat (3) @(negedge clk);
        toggle(t); push_frame(t, d); wait_until(d + 4);

        @(negedge clk);
        rst_n = 1'b0;
        framerate = 1'b1;
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        repeat (40) @(negedge clk);
        check("release_high_dropped", dropped_frames, 0);
        check("release_high_idle", busy, 0);
        toggle(t); push_frame(t, d); wait_until(d + 4);

        buffer_valid = 1'b0;
        repeat (300) begin
          @(negedge clk);
          framerate = ~framerate;
        end
        repeat (3) @(negedge clk);
        check("saturate_dropped", dropped_frames, 255);
        buffer_valid = 1'b1;
        repeat (5) @(negedge clk);
        stim_done = 1'b1;
      end
      begin : monitor
        while (!stim_done) begin
          @(negedge clk);
          if (buffer_swap) begin
            if (sb.size() == 0) begin
              checks++; errors++;
              $display("FAIL unexpected_swap: got swap at cycle %0d, expected none", cyc);
            end else begin
              e = sb.pop_front();
              check("swap_kind", int'(e.done), 0);
              check("swap_cycle", cyc, e.cyc);
              check("busy_at_swap", int'(busy), 1);
            end
            en_cnt  = 0;
            rst_cnt = 0;
          end
          if (frame_done) begin
            if (sb.size() == 0) begin
              checks++; errors++;
              $display("FAIL unexpected_done: got frame_done at cycle %0d, expected none", cyc);
            end else begin
              e = sb.pop_front();
              check("done_kind", int'(e.done), 1);
              check("done_cycle", cyc, e.cyc);
              check("enable_ticks", en_cnt, NL * BPL);
              check("latch_ticks", rst_cnt, RT);
              check("idle_at_done", int'(busy), 0);
            end
          end
          if (bit_tick && encoder_enable) begin
            if (en_cnt == BPL) check("led_step", int'({led_index, bit_index}), int'({8'd1, 5'd0}));
            en_cnt++;
          end
          if (bit_tick && encoder_reset) rst_cnt++;
          if (encoder_enable && encoder_reset) begin
            checks++; errors++;
            $display("FAIL enc_exclusive: got enable=1 reset=1, expected not both (cycle %0d)", cyc);
          end
        end
      end
    join
    check("scoreboard_drained", sb.size(), 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule

// File: doc/led_frame_scheduler.md
LED_FRAME_SCHEDULER -- requirements
Module: led_frame_scheduler

Interface
REQ-001 Parameter NUM_LEDS, default 60, number of LEDs shifted per frame, legal range 1..256.
REQ-002 Parameter BITS_PER_LED, default 24, bits per LED, legal range 1..32.
REQ-003 Parameter RESET_TICKS, default 40, bit_tick count of the latch/reset gap (40 x 1.333 us = 53 us at 750 kHz).
REQ-004 clock_12mhz  in  1  sole clock; all logic on its rising edge.
REQ-005 reset_n  in  1  asynchronous, active-low reset.
REQ-006 framerate  in  1  frame-rate square wave, synchronous to clock_12mhz; each edge (rise or fall) is one frame request.
REQ-007 bit_tick  in  1  one-cycle strobe per LED bit period, 750 kHz nominal.
REQ-008 buffer_valid  in  1  high when a complete frame is available in the frame buffer.
REQ-009 buffer_swap  out  1  one-cycle pulse: the scheduler takes the buffered frame.
REQ-010 encoder_enable  out  1  high while the encoder shifts LED bits.
REQ-011 encoder_reset  out  1  high during the latch gap.
REQ-012 led_index  out  8  index of the LED being shifted.
REQ-013 bit_index  out  5  bit within the current LED, 0 = first bit.
REQ-014 frame_done  out  1  one-cycle pulse at the end of the latch gap.
REQ-015 busy  out  1  high in SHIFT or LATCH.
REQ-016 dropped_frames  out  8  saturating count of frame requests that were lost.

Function
REQ-017 Request detection shall work as follows:
- framerate_prev register plus armed flag.
- A request is asserted in any cycle where armed=1 and framerate != framerate_prev.
- The first cycle after reset release sets armed=1 and generates no request.
REQ-018 The state machine shall have the states IDLE, SHIFT and LATCH, and shall leave reset in IDLE.
REQ-019 IDLE transitions shall be:
- Start condition: (request or pending) and buffer_valid.
- On start, at the next edge: state=SHIFT, buffer_swap=1 for one cycle, encoder_enable=1, led_index=0, bit_index=0, pending=0.
- Latency is one cycle from the cycle the request is sampled.
REQ-020 In IDLE, a request or pending with buffer_valid=0 shall increment dropped_frames, clear pending and leave the state at IDLE.
REQ-021 SHIFT, on each bit_tick:
- bit_index increments.
- When bit_index = BITS_PER_LED-1, bit_index wraps to 0 and led_index increments.
- Cycles without bit_tick hold both indices.
REQ-022 SHIFT exit: a bit_tick with led_index = NUM_LEDS-1 and bit_index = BITS_PER_LED-1 shall produce, at the next edge:
- state=LATCH, encoder_enable=0, encoder_reset=1;
- latch counter=0, led_index=0, bit_index=0.
REQ-023 LATCH:
- Each bit_tick increments the latch counter.
- The bit_tick that brings the count to RESET_TICKS shall produce, at the next edge: state=IDLE, encoder_reset=0, frame_done=1 for one cycle.
REQ-024 A request while busy=1 shall set pending if pending=0, and shall otherwise increment dropped_frames; pending is one entry deep.
REQ-025 A request in the same cycle as the SHIFT-to-LATCH or LATCH-to-IDLE transition shall be treated as a busy request (REQ-024).
- A pending request shall start the next frame from IDLE on the cycle after frame_done, with no extra gap.
REQ-026 dropped_frames shall saturate at 255 and never wrap.
REQ-027 busy shall be registered and equal (state != IDLE).
REQ-028 encoder_enable and encoder_reset shall never both be high.
REQ-029 Every output shall be driven from a register; no combinational path from any input to any output.

Reset
REQ-030 reset_n low shall immediately force:
- state=IDLE;
- all outputs 0;
- pending=0, armed=0, latch counter=0, framerate_prev=0.
REQ-031 Reset asserted mid-SHIFT or mid-LATCH shall abort the frame with no frame_done, and a clean start shall follow after release.
REQ-032 Deassertion shall take effect at the first clock_12mhz rising edge after reset_n goes high.

Verification (bench: NUM_LEDS=2, BITS_PER_LED=24, RESET_TICKS=3)
REQ-033 Basic frame: buffer_valid=1, one framerate edge, bit_tick every 16 cycles.
- buffer_swap pulses once, one cycle after the request.
- encoder_enable is high for exactly 48 bit_ticks.
- led_index steps 0->1 after 24 bit_ticks.
- encoder_reset is high for 3 bit_ticks, then frame_done pulses once.
REQ-034 Starved buffer: framerate edge with buffer_valid=0 -> no buffer_swap, state stays IDLE, dropped_frames=1.
REQ-035 Overlapping requests: two framerate edges during SHIFT -> pending set by the first, dropped_frames +1 for the second; the next frame starts the cycle after frame_done.
REQ-036 Saturation: 300 requests with buffer_valid=0 -> dropped_frames=255.
REQ-037 Mid-frame reset: reset_n low at led_index=1, bit_index=10 -> all outputs 0 at once, no frame_done; after release a new edge yields a full 48-bit frame.
REQ-038 Reset release with framerate=1 -> no request is generated, and no buffer_swap occurs until the next framerate edge.
